// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared ALU datapath constants and the nibble-serial subtractor  |
// |            FSM state encoding.                                             |
// | Contents : ALU_WIDTH  - default datapath width (16)                        |
// |            NIBBLE_W   - width of one look-ahead slice (4)                  |
// |            sub_state_t - IDLE / RUN / DONE                                 |
// | Config   : none (ALU_SUB_SATURATE_EN is consumed by the subtractor top)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

   localparam int ALU_WIDTH = 16;
   localparam int NIBBLE_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/nibble_serial_subtractor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nibble_serial_subtractor_if                                     |
// | Purpose  : Operand and result handshake bundle of the nibble-serial        |
// |            subtractor.                                                     |
// | Signals  : in_valid/in_ready, a, b, b_in       - operand side              |
// |            out_valid/out_ready, diff, b_out,                               |
// |            zero, overflow                      - result side               |
// | Modports : master - operand producer / result consumer                     |
// |            slave  - the subtractor                                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface nibble_serial_subtractor_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             b_out;
   logic             zero;
   logic             overflow;

   modport master (
      output in_valid, a, b, b_in, out_ready,
      input  in_ready, out_valid, diff, b_out, zero, overflow
   );

   modport slave (
      input  in_valid, a, b, b_in, out_ready,
      output in_ready, out_valid, diff, b_out, zero, overflow
   );

endinterface : nibble_serial_subtractor_if
`default_nettype wire

// File: rtl/nibble_serial_subtractor_blg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : borrow_look_ahead_generator                                     |
// | Purpose  : 4-bit combinational borrow look-ahead subtract slice,           |
// |            diff = a - b - borrow_in. Two-level look-ahead: every borrow    |
// |            is a flat sum of products of the slice P/G terms.               |
// | Ports    : a, b        in  4  minuend / subtrahend nibble                  |
// |            borrow_in   in  1  borrow into bit 0                            |
// |            diff        out 4  difference nibble                            |
// |            borrow_out  out 4  B1..B4 (borrow_out[3] leaves the nibble)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module borrow_look_ahead_generator
   import alu_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                borrow_in,
   output logic [NIBBLE_W-1:0] diff,
   output logic [NIBBLE_W-1:0] borrow_out
);

   // P: bit passes an incoming borrow on (a == b); G: bit creates a borrow (0 - 1)
   logic [NIBBLE_W-1:0] w_p;
   logic [NIBBLE_W-1:0] w_g;
   logic [NIBBLE_W-1:0] w_borrow_into_bit;

   assign w_p = ~(a ^ b);
   assign w_g = ~a & b;

   assign borrow_out[0] = w_g[0]
                        | (w_p[0] & borrow_in);
   assign borrow_out[1] = w_g[1]
                        | (w_p[1] & w_g[0])
                        | (w_p[1] & w_p[0] & borrow_in);
   assign borrow_out[2] = w_g[2]
                        | (w_p[2] & w_g[1])
                        | (w_p[2] & w_p[1] & w_g[0])
                        | (w_p[2] & w_p[1] & w_p[0] & borrow_in);
   assign borrow_out[3] = w_g[3]
                        | (w_p[3] & w_g[2])
                        | (w_p[3] & w_p[2] & w_g[1])
                        | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                        | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & borrow_in);

   assign w_borrow_into_bit = {borrow_out[NIBBLE_W-2:0], borrow_in};
   assign diff              = a ^ b ^ w_borrow_into_bit;

endmodule : borrow_look_ahead_generator
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : nibble_serial_subtractor                                        |
// | Purpose  : Multi-cycle A - B - b_in, one nibble per clock LSB first,       |
// |            through a single time-multiplexed borrow look-ahead slice.      |
// |            Produces borrow-out, zero and signed-overflow flags.            |
// | Ports    : clk    in  rising-edge clock                                    |
// |            rst_n  in  asynchronous active-low reset                        |
// |            bus    slave modport of nibble_serial_subtractor_if             |
// | Params   : WIDTH  operand width, a multiple of 4                           |
// | Config   : ALU_SUB_SATURATE_EN - when defined, an unsigned underflow       |
// |            forces diff to 0 (zero=1); b_out/overflow still reported.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module nibble_serial_subtractor
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
)(
   input  logic                        clk,
   input  logic                        rst_n,
   nibble_serial_subtractor_if.slave   bus
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

   sub_state_t          r_state;
   sub_state_t          w_state_next;

   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_diff;
   logic                r_borrow;
   logic [IDX_W-1:0]    r_idx;
   logic                r_out_valid;
   logic                r_b_out;
   logic                r_zero;
   logic                r_overflow;

   logic [NIBBLE_W-1:0] w_a_nib;
   logic [NIBBLE_W-1:0] w_b_nib;
   logic [NIBBLE_W-1:0] w_d_nib;
   logic [NIBBLE_W-1:0] w_borrows;
   logic                w_nib_borrow;
   logic                w_unused_inner_borrows;
   logic                w_accept;
   logic                w_last;
   logic [WIDTH-1:0]    w_diff_raw;
   logic [WIDTH-1:0]    w_diff_final;
   logic                w_ovf;

   assign w_accept = bus.in_valid & bus.in_ready;
   assign w_last   = (r_state == RUN) && (r_idx == C_LAST_IDX);

   assign w_a_nib = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
   assign w_b_nib = r_b[r_idx*NIBBLE_W +: NIBBLE_W];

   borrow_look_ahead_generator u_blg (
      .a          (w_a_nib),
      .b          (w_b_nib),
      .borrow_in  (r_borrow),
      .diff       (w_d_nib),
      .borrow_out (w_borrows)
   );

   // Only the borrow leaving the nibble is carried to the next cycle
   assign w_nib_borrow           = w_borrows[NIBBLE_W-1];
   assign w_unused_inner_borrows = ^w_borrows[NIBBLE_W-2:0];

   // Diff register with the current nibble merged in
   always_comb begin
      w_diff_raw = r_diff;
      w_diff_raw[r_idx*NIBBLE_W +: NIBBLE_W] = w_d_nib;
   end

   // Overflow is judged on the unsaturated result
   assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                  (w_diff_raw[WIDTH-1] != r_a[WIDTH-1]);

`ifdef ALU_SUB_SATURATE_EN
   assign w_diff_final = w_nib_borrow ? '0 : w_diff_raw;
`else
   assign w_diff_final = w_diff_raw;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (bus.in_valid)  w_state_next = RUN;
         RUN:     if (w_last)        w_state_next = DONE;
         DONE:    if (bus.out_ready) w_state_next = IDLE;
         default:                    w_state_next = IDLE;
      endcase
   end

   // Operand latch, nibble sequencing and result/flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_diff      <= '0;
         r_borrow    <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_b_out     <= 1'b0;
         r_zero      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= bus.b_in;
            r_idx    <= '0;
         end
         if (r_state == RUN) begin
            // Saturation may only be applied once the whole word is known
            r_diff   <= w_last ? w_diff_final : w_diff_raw;
            r_borrow <= w_nib_borrow;
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
               r_out_valid <= 1'b1;
               r_b_out     <= w_nib_borrow;
               r_zero      <= (w_diff_final == '0);
               r_overflow  <= w_ovf;
            end
         end
         if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.diff      = r_diff;
   assign bus.b_out     = r_b_out;
   assign bus.zero      = r_zero;
   assign bus.overflow  = r_overflow;

endmodule : nibble_serial_subtractor
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_nibble_serial_subtractor                                     |
// | Purpose  : Self-checking bench for nibble_serial_subtractor. Expected      |
// |            results come from whole-word integer arithmetic; directed       |
// |            corner cases are followed by randomized operands and stalls.    |
// | Config   : honours ALU_SUB_SATURATE_EN in its reference model              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_nibble_serial_subtractor;

   localparam int WIDTH = 16;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   nibble_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One complete transaction: issue, measure latency, hold in DONE for
   // 'stall' cycles (optionally with a competing in_valid), then hand off.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tbin, input int stall, input bit hold_in,
                         input string tag);
      logic [WIDTH:0]   full;
      logic [WIDTH-1:0] e_diff;
      logic             e_bout;
      logic             e_zero;
      logic             e_ovf;
      int               sres;
      int               cycles;

      full   = {1'b0, ta} - {1'b0, tb_v} - {{WIDTH{1'b0}}, tbin};
      e_bout = full[WIDTH];
      e_diff = full[WIDTH-1:0];
      sres   = int'($signed(ta)) - int'($signed(tb_v)) - int'(tbin);
      e_ovf  = (sres > 32767) || (sres < -32768);
`ifdef ALU_SUB_SATURATE_EN
      if (e_bout) e_diff = '0;
`endif
      e_zero = (e_diff == '0);

      @(negedge clk);
      check({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a        = ta;
      bus.b        = tb_v;
      bus.b_in     = tbin;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.b_in     = 1'($urandom);

      cycles = 0;
      while (!bus.out_valid && cycles < 12) begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end
      check({tag, ".latency"}, 32'(cycles), 32'd4);
      check({tag, ".diff"},    32'(bus.diff), 32'(e_diff));
      check({tag, ".b_out"},   32'(bus.b_out), 32'(e_bout));
      check({tag, ".zero"},    32'(bus.zero), 32'(e_zero));
      check({tag, ".ovf"},     32'(bus.overflow), 32'(e_ovf));

      for (int s = 0; s < stall; s++) begin
         if (hold_in) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
         end
         @(posedge clk);
         @(negedge clk);
         check({tag, ".stall_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, ".stall_ready"}, 32'(bus.in_ready), 32'd0);
         check({tag, ".stall_diff"},  {15'd0, bus.b_out, bus.diff}, {15'd0, e_bout, e_diff});
         check({tag, ".stall_flags"}, {30'd0, bus.zero, bus.overflow}, {30'd0, e_zero, e_ovf});
      end

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, ".handoff_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".handoff_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;

      n_checks      = 0;
      n_errors      = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.b_in      = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst.in_ready",  32'(bus.in_ready), 32'd1);
      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.diff",      32'(bus.diff), 32'd0);
      check("rst.flags",     {29'd0, bus.b_out, bus.zero, bus.overflow}, 32'd0);
      rst_n = 1'b1;

      // Directed corner cases
      run_op(16'h1234, 16'h0234, 1'b0, 0, 1'b0, "basic");
      run_op(16'h0000, 16'h0001, 1'b0, 1, 1'b0, "underflow");
      run_op(16'h8000, 16'h0001, 1'b0, 0, 1'b0, "ovf_neg");
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0, "ovf_pos");
      run_op(16'h0005, 16'h0005, 1'b0, 0, 1'b0, "equal");
      run_op(16'h0005, 16'h0005, 1'b1, 0, 1'b0, "equal_bin");
      run_op(16'h8000, 16'h0000, 1'b1, 0, 1'b0, "ovf_bin");
      run_op(16'h1234, 16'h0234, 1'b0, 3, 1'b1, "backpressure");

      // Reset during the second RUN cycle discards the partial result
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'hFFFF;
      bus.b        = 16'h0001;
      bus.b_in     = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst.diff",      32'(bus.diff), 32'd0);
      check("midrst.in_ready",  32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst.out_valid_after", 32'(bus.out_valid), 32'd0);
      run_op(16'h0010, 16'h0001, 1'b0, 0, 1'b0, "post_rst");

      // Randomized operands and result-side stalls
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = (i % 8 == 0) ? ra : 16'($urandom);
         run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_nibble_serial_subtractor
`default_nettype wire
